// File: rtl/ofmap_writeback_ctrl_pkg.sv
// Shared types and default geometry for the ofmap writeback controller.
package ofmap_pkg;

   localparam int OF_WD     = 8;
   localparam int OF_IN     = 4;
   localparam int OF_FI     = 3;
   localparam int OF_PE_COL = 8;
   localparam int OF_ADDR_W = 10;
   localparam int OF_CNT_W  = 8;

   localparam int PSUM_W  = 2 * OF_WD;
   localparam int WORD_W  = OF_PE_COL * OF_WD;
   localparam int MSB_IDX = OF_IN + 2 * OF_FI;
   localparam int LSB_IDX = OF_FI;

   typedef enum logic [2:0] {IDLE, LOAD, ACT, WRITE, DONE} state_e;

endpackage

// File: rtl/ofmap_writeback_ctrl_if.sv
// Psum-row input and ofmap-write handshakes. The controller uses the master
// modport; the PE array / SRAM side uses slave.
interface ofmap_writeback_ctrl_if
   import ofmap_pkg::*;
#(
   parameter int WD     = OF_WD,
   parameter int PE_COL = OF_PE_COL,
   parameter int ADDR_W = OF_ADDR_W
);
   logic                     psum_vld;
   logic                     psum_rdy;
   logic [PE_COL*2*WD-1:0]   psum_row;
   logic                     of_vld;
   logic                     of_rdy;
   logic [ADDR_W-1:0]        of_addr;
   logic [PE_COL*WD-1:0]     of_data;

   modport master (
      input  psum_vld, psum_row, of_rdy,
      output psum_rdy, of_vld, of_addr, of_data
   );

   modport slave (
      output psum_vld, psum_row, of_rdy,
      input  psum_rdy, of_vld, of_addr, of_data
   );
endinterface

// File: rtl/ofmap_writeback_ctrl_lane.sv
// Single combinational ReLU + fixed-point truncation lane.
// OFMAP_SAT_EN: clamp positive overflow to the max positive activation.
module relu_trunc_lane #(
   parameter int WD = 8,
   parameter int IN = 4,
   parameter int FI = 3
) (
   input  logic            en,
   input  logic [2*WD-1:0] psum,
   output logic [WD-1:0]   act
);
   localparam int PW  = 2 * WD;
   localparam int MSB = IN + 2 * FI;
   localparam int LSB = FI;

   if (IN + FI + 1 != WD) begin : g_bad_fmt
      $error("relu_trunc_lane: IN+FI+1 must equal WD");
   end

   logic unused_bits;
   assign unused_bits = ^psum;

   always_comb begin
      act = '0;
      if (en && !psum[PW-1]) begin
`ifdef OFMAP_SAT_EN
         // any set bit from the result sign upward is unrepresentable
         act = (|psum[PW-2:MSB]) ? {1'b0, {(WD-1){1'b1}}} : psum[MSB:LSB];
`else
         act = psum[MSB:LSB];
`endif
      end
   end
endmodule

// File: rtl/ofmap_writeback_ctrl.sv
// Writes one output tile: accept a psum row, activate it column by column
// through one shared lane, pack to a word, write at base+row. OFMAP_SAT_EN
// selects saturating activation in the lane.
module ofmap_writeback_ctrl
   import ofmap_pkg::*;
#(
   parameter int WD     = OF_WD,
   parameter int IN     = OF_IN,
   parameter int FI     = OF_FI,
   parameter int PE_COL = OF_PE_COL,
   parameter int ADDR_W = OF_ADDR_W,
   parameter int CNT_W  = OF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 clr,
   input  logic [CNT_W-1:0]     cfg_rows,
   input  logic [ADDR_W-1:0]    cfg_base,
   ofmap_writeback_ctrl_if.master bus,
   output logic                 busy,
   output logic                 done
);
   localparam int PW    = 2 * WD;
   localparam int COL_W = (PE_COL > 1) ? $clog2(PE_COL) : 1;

   state_e state_q, state_d;

   logic [CNT_W-1:0]             rows_q, row_idx_q, row_nxt;
   logic [ADDR_W-1:0]            base_q;
   logic [COL_W-1:0]             col_q;
   logic [PE_COL-1:0][PW-1:0]    psum_q;
   logic [PE_COL-1:0][WD-1:0]    pack_q;
   logic                         lane_en;
   logic [WD-1:0]                lane_act;
   logic                         last_col, last_row;

   assign row_nxt  = row_idx_q + CNT_W'(1);
   assign last_row = (row_nxt == rows_q);
   assign last_col = (col_q == COL_W'(PE_COL - 1));

   assign bus.of_addr = base_q + ADDR_W'(row_idx_q);
   assign bus.of_data = pack_q;

   relu_trunc_lane #(.WD(WD), .IN(IN), .FI(FI)) u_lane (
      .en   (lane_en),
      .psum (psum_q[col_q]),
      .act  (lane_act)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = (cfg_rows == '0) ? DONE : LOAD;
            LOAD:    if (bus.psum_vld) state_d = ACT;
            ACT:     if (last_col) state_d = WRITE;
            WRITE:   if (bus.of_rdy) state_d = last_row ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // clr also masks the handshakes in its own cycle so no transfer slips through
   always_comb begin
      bus.psum_rdy = 1'b0;
      bus.of_vld   = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      lane_en      = 1'b0;
      case (state_q)
         IDLE:    busy = 1'b0;
         LOAD:    bus.psum_rdy = !clr;
         ACT:     lane_en = 1'b1;
         WRITE:   bus.of_vld = !clr;
         DONE:    done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows_q    <= '0;
         base_q    <= '0;
         row_idx_q <= '0;
         col_q     <= '0;
         psum_q    <= '0;
         pack_q    <= '0;
      end else if (!clr) begin
         case (state_q)
            IDLE: if (start && cfg_rows != '0) begin
               rows_q    <= cfg_rows;
               base_q    <= cfg_base;
               row_idx_q <= '0;
            end
            LOAD: if (bus.psum_vld) begin
               psum_q <= bus.psum_row;
               col_q  <= '0;
            end
            ACT: begin
               pack_q[col_q] <= lane_act;
               col_q         <= col_q + COL_W'(1);
            end
            WRITE: if (bus.of_rdy) row_idx_q <= row_nxt;
            default: ;
         endcase
      end
   end
endmodule
